dca_matrix_addr_gen: RTL and testbench
======================================

Name: dca_matrix_addr_gen

Overview:
- Upstream address generator for DCA matrix load/store engines.
- On a start pulse, latches a matrix descriptor and walks every element in row-major or column-major order.
- Emits one memory request address per valid/ready handshake, tagged with first/last and end-of-line flags for the downstream data path.
- Position tracking uses one dca_matrix_iterator instance; address arithmetic is local.

Parameters:
BW_ADDR, 32, request address width
BW_NUM_ROW, 8, width of row count minus one
BW_NUM_COL, 8, width of column count minus one
BW_STRIDE, 16, width of row/column byte strides (unsigned)

Ports:
clk  input  1  clock
rstnn  input  1  asynchronous active-low reset
clear  input  1  synchronous abort, highest priority after reset
start  input  1  launch pulse, sampled only in IDLE
cfg_is_col_first  input  1  1: x = column (row-major walk); 0: x = row
cfg_num_row_m1  input  BW_NUM_ROW  rows minus one
cfg_num_col_m1  input  BW_NUM_COL  columns minus one
cfg_base_addr  input  BW_ADDR  address of element (0,0)
cfg_row_stride  input  BW_STRIDE  byte step between adjacent rows
cfg_col_stride  input  BW_STRIDE  byte step between adjacent columns
busy  output  1  high from cycle after accepted start until DONE exits
done  output  1  one-cycle pulse after last request accepted
req_valid  output  1  request address valid
req_ready  input  1  downstream accepts request
req_addr  output  BW_ADDR  element address
req_first  output  1  request is element (0,0)
req_last  output  1  request is final element
req_last_x  output  1  request closes current inner line

Behaviour:
- Reset (rstnn=0, async): state=IDLE; busy, done, req_valid, req_first, req_last, req_last_x = 0; req_addr = 0; iterator cleared.
- States: IDLE, RUN, DONE.
- IDLE: if start, latch all cfg_* and load line_base = cur_addr = cfg_base_addr; clear iterator; go to RUN. start in RUN/DONE ignored. cfg_* inputs ignored except in the start cycle.
- Latency: start at cycle t gives req_valid=1 with req_addr=base at t+1; busy=1 from t+1.
- RUN: req_valid=1. req_addr=cur_addr.
  - req_first = iterator is_first_element.
  - req_last = is_last_element.
  - req_last_x = is_last_x.
- Handshake: hs = req_valid & req_ready. While valid & ~ready, req_addr and all flags hold stable. Throughput is one request per cycle.
- x_stride = col_stride if is_col_first, else row_stride; y_stride is the other one. Both are zero-extended to BW_ADDR. Sums wrap modulo 2^BW_ADDR with no error flag.
- On hs, the iterator is driven with iterate = hs & ~is_last_x and go_next_base = hs & is_last_x. Address update:
  - If req_last: go to DONE.
  - Else if is_last_x: line_base += y_stride and cur_addr = line_base + y_stride.
  - Else: cur_addr += x_stride.
- DONE: req_valid=0, done=1 for exactly one cycle, busy stays 1 that cycle, then IDLE with busy=0. A start arriving during DONE is dropped.
- Degenerate 1x1 (both m1 = 0): a single request with first=last=last_x=1.
- Single line (y count 1): last_x=1 only on the final request.
- clear: from any state, next cycle is IDLE. req_valid, busy and done drop and no done pulse is generated. The iterator is cleared. A request pending at clear is withdrawn. clear beats start in the same cycle.
- Reset mid-operation behaves the same as clear, but asynchronously.

Decomposition:
- Shared package dca_addr_gen_pkg:
  - FSM state encoding (IDLE=0, RUN=1, DONE=2, 2 bits).
  - Descriptor field widths.
- Sub-module: dca_matrix_iterator for row/column position and first/last flags, with enable tied high and clear = clear | (IDLE & start).
- Stride selection and the address adders stay in this block.

Test Plan:
- Row-major 2x3 (row_m1=1, col_m1=2), base=0x1000, col_stride=4, row_stride=0x100, ready always 1 -> addrs 0x1000,0x1004,0x1008,0x1100,0x1104,0x1108 on consecutive cycles. last_x on the 3rd and 6th, first on the 1st, last on the 6th. done pulses the cycle after the 6th.
- Same descriptor with cfg_is_col_first=0 -> addrs 0x1000,0x1100,0x1004,0x1104,0x1008,0x1108. last_x on every 2nd request.
- Backpressure: ready toggles 1,0,0,1,... on the row-major case -> req_addr and flags stay stable during ready=0, sequence is unchanged, and exactly 6 handshakes occur.
- 1x1, base=0xFFFFFFFC -> one request with first=last=last_x=1, then done. Then a 1x2 run with col_stride=8 from 0xFFFFFFFC -> addrs 0xFFFFFFFC, 0x00000004 (wrap).
- clear asserted after 2 handshakes of the 2x3 case -> req_valid=0 and busy=0 next cycle, no done. A new start then restarts at base with req_first=1.
- start pulsed during RUN and during DONE -> ignored, with no change to the sequence or descriptor. Async rstnn low mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/dca_addr_gen_pkg.sv
// Shared types and widths for the DCA matrix address generator.
// Holds the FSM encoding and the default descriptor field widths.
package dca_addr_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } addr_gen_state_e;

    localparam int BW_ADDR_DEF    = 32;
    localparam int BW_NUM_ROW_DEF = 8;
    localparam int BW_NUM_COL_DEF = 8;
    localparam int BW_STRIDE_DEF  = 16;

    // The iterator counters must hold either dimension, whichever is wider.
    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dca_matrix_addr_gen_if.sv
// Request bus from the address generator to the memory engine.
// The master drives the address and flags, and the slave returns ready.
interface dca_matrix_addr_gen_if #(
    parameter int BW_ADDR = 32
);
    logic               req_valid;
    logic               req_ready;
    logic [BW_ADDR-1:0] req_addr;
    logic               req_first;
    logic               req_last;
    logic               req_last_x;

    modport master (
        output req_valid, req_addr, req_first, req_last, req_last_x,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_first, req_last, req_last_x,
        output req_ready
    );
endinterface

// File: rtl/dca_matrix_iterator.sv
// Tracks the (x, y) position of a matrix walk and decodes the first and last flags.
// x is the inner dimension. go_next_base wraps x to 0 and advances y.
module dca_matrix_iterator #(
    parameter int BW_CNT = 8
) (
    input  logic              clk,
    input  logic              rstnn,
    input  logic              clear,
    input  logic              enable,
    input  logic              iterate,
    input  logic              go_next_base,
    input  logic [BW_CNT-1:0] num_x_m1,
    input  logic [BW_CNT-1:0] num_y_m1,
    output logic              is_first_element,
    output logic              is_last_element,
    output logic              is_last_x
);

    localparam logic [BW_CNT-1:0] CNT_ZERO = BW_CNT'(0);
    localparam logic [BW_CNT-1:0] CNT_ONE  = BW_CNT'(1);

    logic [BW_CNT-1:0] x_cnt_r;
    logic [BW_CNT-1:0] y_cnt_r;

    // Position counters, where a line change takes priority over stepping along x.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            x_cnt_r <= CNT_ZERO;
            y_cnt_r <= CNT_ZERO;
        end else if (clear) begin
            x_cnt_r <= CNT_ZERO;
            y_cnt_r <= CNT_ZERO;
        end else if (enable && go_next_base) begin
            x_cnt_r <= CNT_ZERO;
            y_cnt_r <= y_cnt_r + CNT_ONE;
        end else if (enable && iterate) begin
            x_cnt_r <= x_cnt_r + CNT_ONE;
        end else begin
            x_cnt_r <= x_cnt_r;
            y_cnt_r <= y_cnt_r;
        end
    end

    assign is_first_element = (x_cnt_r == CNT_ZERO) && (y_cnt_r == CNT_ZERO);
    assign is_last_x        = (x_cnt_r == num_x_m1);
    assign is_last_element  = is_last_x && (y_cnt_r == num_y_m1);

endmodule

// File: rtl/dca_matrix_addr_gen.sv
// Walks a latched matrix descriptor in row-major or column-major order.
// It issues one element address per handshake, with first, last and end-of-line tags.
module dca_matrix_addr_gen
    import dca_addr_gen_pkg::*;
#(
    parameter int BW_ADDR    = BW_ADDR_DEF,
    parameter int BW_NUM_ROW = BW_NUM_ROW_DEF,
    parameter int BW_NUM_COL = BW_NUM_COL_DEF,
    parameter int BW_STRIDE  = BW_STRIDE_DEF
) (
    input  logic                  clk,
    input  logic                  rstnn,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  cfg_is_col_first,
    input  logic [BW_NUM_ROW-1:0] cfg_num_row_m1,
    input  logic [BW_NUM_COL-1:0] cfg_num_col_m1,
    input  logic [BW_ADDR-1:0]    cfg_base_addr,
    input  logic [BW_STRIDE-1:0]  cfg_row_stride,
    input  logic [BW_STRIDE-1:0]  cfg_col_stride,
    output logic                  busy,
    output logic                  done,
    dca_matrix_addr_gen_if.master req
);

    localparam int BW_CNT = max_width(BW_NUM_ROW, BW_NUM_COL);

    addr_gen_state_e state_r, state_nx_s;

    logic                  is_col_first_r;
    logic [BW_NUM_ROW-1:0] num_row_m1_r;
    logic [BW_NUM_COL-1:0] num_col_m1_r;
    logic [BW_STRIDE-1:0]  row_stride_r;
    logic [BW_STRIDE-1:0]  col_stride_r;
    logic [BW_ADDR-1:0]    line_base_r;
    logic [BW_ADDR-1:0]    cur_addr_r;

    logic                  run_s, hs_s, launch_s, iter_clear_s;
    logic                  is_first_s, is_last_s, is_last_x_s;
    logic [BW_CNT-1:0]     num_x_m1_s, num_y_m1_s;
    logic [BW_ADDR-1:0]    x_stride_s, y_stride_s, next_line_base_s;

    assign run_s    = (state_r == ST_RUN);
    assign hs_s     = run_s && req.req_ready;
    assign launch_s = (state_r == ST_IDLE) && start;
    assign iter_clear_s = clear || launch_s;

    // The inner dimension x is the column axis in a row-major walk, and the row axis otherwise.
    assign num_x_m1_s = is_col_first_r ? BW_CNT'(num_col_m1_r) : BW_CNT'(num_row_m1_r);
    assign num_y_m1_s = is_col_first_r ? BW_CNT'(num_row_m1_r) : BW_CNT'(num_col_m1_r);
    assign x_stride_s = is_col_first_r ? BW_ADDR'(col_stride_r) : BW_ADDR'(row_stride_r);
    assign y_stride_s = is_col_first_r ? BW_ADDR'(row_stride_r) : BW_ADDR'(col_stride_r);
    assign next_line_base_s = line_base_r + y_stride_s;

    dca_matrix_iterator #(
        .BW_CNT (BW_CNT)
    ) u_iterator (
        .clk              (clk),
        .rstnn            (rstnn),
        .clear            (iter_clear_s),
        .enable           (1'b1),
        .iterate          (hs_s && !is_last_x_s),
        .go_next_base     (hs_s && is_last_x_s),
        .num_x_m1         (num_x_m1_s),
        .num_y_m1         (num_y_m1_s),
        .is_first_element (is_first_s),
        .is_last_element  (is_last_s),
        .is_last_x        (is_last_x_s)
    );

    // Next-state logic, where clear overrides every transition.
    always_comb begin
        state_nx_s = state_r;
        if (clear) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nx_s = start ? ST_RUN : ST_IDLE;
                ST_RUN:  state_nx_s = (hs_s && is_last_s) ? ST_DONE : ST_RUN;
                ST_DONE: state_nx_s = ST_IDLE;
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Descriptor latch and address walk, with modulo-2^BW_ADDR arithmetic.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            is_col_first_r <= 1'b0;
            num_row_m1_r   <= '0;
            num_col_m1_r   <= '0;
            row_stride_r   <= '0;
            col_stride_r   <= '0;
            line_base_r    <= '0;
            cur_addr_r     <= '0;
        end else if (clear) begin
            line_base_r    <= '0;
            cur_addr_r     <= '0;
        end else if (launch_s) begin
            is_col_first_r <= cfg_is_col_first;
            num_row_m1_r   <= cfg_num_row_m1;
            num_col_m1_r   <= cfg_num_col_m1;
            row_stride_r   <= cfg_row_stride;
            col_stride_r   <= cfg_col_stride;
            line_base_r    <= cfg_base_addr;
            cur_addr_r     <= cfg_base_addr;
        end else if (hs_s && !is_last_s && is_last_x_s) begin
            line_base_r    <= next_line_base_s;
            cur_addr_r     <= next_line_base_s;
        end else if (hs_s && !is_last_s) begin
            cur_addr_r     <= cur_addr_r + x_stride_s;
        end else begin
            cur_addr_r     <= cur_addr_r;
        end
    end

    assign busy           = (state_r != ST_IDLE);
    assign done           = (state_r == ST_DONE);
    assign req.req_valid  = run_s;
    assign req.req_addr   = cur_addr_r;
    assign req.req_first  = run_s && is_first_s;
    assign req.req_last   = run_s && is_last_s;
    assign req.req_last_x = run_s && is_last_x_s;

endmodule

// File: tb/tb_dca_matrix_addr_gen.sv
// Directed bench for dca_matrix_addr_gen with hand-computed address sequences.
// Inputs change and outputs are sampled on the falling edge.
module tb_dca_matrix_addr_gen;

    logic        clk = 1'b0;
    logic        rstnn, clear, start, cfg_is_col_first;
    logic [7:0]  cfg_num_row_m1, cfg_num_col_m1;
    logic [31:0] cfg_base_addr;
    logic [15:0] cfg_row_stride, cfg_col_stride;
    logic        busy, done;

    logic [31:0] exp_addr [8];
    logic        exp_lx   [8];
    int pass_cnt = 0;
    int total_cnt = 0;

    dca_matrix_addr_gen_if #(.BW_ADDR(32)) req_if ();

    dca_matrix_addr_gen dut (
        .clk              (clk),
        .rstnn            (rstnn),
        .clear            (clear),
        .start            (start),
        .cfg_is_col_first (cfg_is_col_first),
        .cfg_num_row_m1   (cfg_num_row_m1),
        .cfg_num_col_m1   (cfg_num_col_m1),
        .cfg_base_addr    (cfg_base_addr),
        .cfg_row_stride   (cfg_row_stride),
        .cfg_col_stride   (cfg_col_stride),
        .busy             (busy),
        .done             (done),
        .req              (req_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " valid"}, 32'(req_if.req_valid), 32'd0);
        check({tag, " busy"},  32'(busy),             32'd0);
        check({tag, " done"},  32'(done),             32'd0);
        check({tag, " first"}, 32'(req_if.req_first), 32'd0);
    endtask

    // After start is taken, the cfg pins are driven with junk to show that the descriptor was latched.
    task automatic launch(input logic cf, input logic [7:0] rm1, input logic [7:0] cm1,
                          input logic [31:0] base, input logic [15:0] rs, input logic [15:0] cs);
        cfg_is_col_first = cf;
        cfg_num_row_m1   = rm1;
        cfg_num_col_m1   = cm1;
        cfg_base_addr    = base;
        cfg_row_stride   = rs;
        cfg_col_stride   = cs;
        start            = 1'b1;
        @(negedge clk);
        start            = 1'b0;
        cfg_is_col_first = ~cf;
        cfg_num_row_m1   = 8'd7;
        cfg_num_col_m1   = 8'd7;
        cfg_base_addr    = 32'hDEAD_BEEF;
        cfg_row_stride   = 16'h0123;
        cfg_col_stride   = 16'h0456;
    endtask

    task automatic run_expect(input string tag, input int n, input bit bp, input bit inj);
        int idx = 0;
        int cyc = 0;
        bit rdy;
        while (idx < n && cyc < 64) begin
            rdy = bp ? (cyc % 3 == 0) : 1'b1;
            req_if.req_ready = rdy;
            start = inj && (cyc == 1);
            check({tag, " valid"},  32'(req_if.req_valid),  32'd1);
            check({tag, " busy"},   32'(busy),              32'd1);
            check({tag, " addr"},   req_if.req_addr,        exp_addr[idx]);
            check({tag, " first"},  32'(req_if.req_first),  32'(idx == 0));
            check({tag, " last"},   32'(req_if.req_last),   32'(idx == n - 1));
            check({tag, " last_x"}, 32'(req_if.req_last_x), 32'(exp_lx[idx]));
            if (rdy) idx++;
            cyc++;
            @(negedge clk);
        end
        check({tag, " handshakes"}, 32'(idx), 32'(n));
        start = inj;
        req_if.req_ready = 1'b1;
        check({tag, " done valid"}, 32'(req_if.req_valid), 32'd0);
        check({tag, " done pulse"}, 32'(done), 32'd1);
        check({tag, " done busy"},  32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        check_idle({tag, " post"});
    endtask

    task automatic set_row_major;
        exp_addr[0] = 32'h1000; exp_addr[1] = 32'h1004; exp_addr[2] = 32'h1008;
        exp_addr[3] = 32'h1100; exp_addr[4] = 32'h1104; exp_addr[5] = 32'h1108;
        exp_lx[0] = 1'b0; exp_lx[1] = 1'b0; exp_lx[2] = 1'b1;
        exp_lx[3] = 1'b0; exp_lx[4] = 1'b0; exp_lx[5] = 1'b1;
    endtask

    initial begin
        rstnn = 1'b0; clear = 1'b0; start = 1'b0; req_if.req_ready = 1'b1;
        cfg_is_col_first = 1'b0; cfg_num_row_m1 = 8'd0; cfg_num_col_m1 = 8'd0;
        cfg_base_addr = 32'd0; cfg_row_stride = 16'd0; cfg_col_stride = 16'd0;
        @(negedge clk);
        check_idle("reset");
        check("reset addr", req_if.req_addr, 32'd0);
        rstnn = 1'b1;
        @(negedge clk);

        // 2x3 row-major walk with ready held high.
        set_row_major();
        launch(1'b1, 8'd1, 8'd2, 32'h1000, 16'h0100, 16'h0004);
        run_expect("rowmaj", 6, 1'b0, 1'b0);

        // The same descriptor walked column-major, with stray start pulses in RUN and in DONE.
        exp_addr[0] = 32'h1000; exp_addr[1] = 32'h1100; exp_addr[2] = 32'h1004;
        exp_addr[3] = 32'h1104; exp_addr[4] = 32'h1008; exp_addr[5] = 32'h1108;
        exp_lx[0] = 1'b0; exp_lx[1] = 1'b1; exp_lx[2] = 1'b0;
        exp_lx[3] = 1'b1; exp_lx[4] = 1'b0; exp_lx[5] = 1'b1;
        launch(1'b0, 8'd1, 8'd2, 32'h1000, 16'h0100, 16'h0004);
        run_expect("colmaj", 6, 1'b0, 1'b1);

        // Row-major walk with backpressure on ready (pattern 1,0,0,...).
        set_row_major();
        launch(1'b1, 8'd1, 8'd2, 32'h1000, 16'h0100, 16'h0004);
        run_expect("bp", 6, 1'b1, 1'b0);

        // 1x1 walk at the top of the address space.
        exp_addr[0] = 32'hFFFF_FFFC; exp_lx[0] = 1'b1;
        launch(1'b1, 8'd0, 8'd0, 32'hFFFF_FFFC, 16'h0100, 16'h0004);
        run_expect("1x1", 1, 1'b0, 1'b0);

        // 1x2 walk whose address wraps past zero.
        exp_addr[1] = 32'h0000_0004; exp_lx[0] = 1'b0; exp_lx[1] = 1'b1;
        launch(1'b1, 8'd0, 8'd1, 32'hFFFF_FFFC, 16'h0100, 16'h0008);
        run_expect("wrap", 2, 1'b0, 1'b0);

        // clear after two handshakes, clear winning over start in IDLE, then a clean restart.
        set_row_major();
        launch(1'b1, 8'd1, 8'd2, 32'h1000, 16'h0100, 16'h0004);
        check("clr a0", req_if.req_addr, 32'h1000);
        @(negedge clk);
        check("clr a1", req_if.req_addr, 32'h1004);
        @(negedge clk);
        check("clr a2", req_if.req_addr, 32'h1008);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_idle("clr");
        @(negedge clk);
        check("clr no done", 32'(done), 32'd0);
        clear = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        check_idle("clr+start");
        launch(1'b1, 8'd1, 8'd2, 32'h1000, 16'h0100, 16'h0004);
        run_expect("restart", 6, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a walk.
        launch(1'b1, 8'd1, 8'd2, 32'h1000, 16'h0100, 16'h0004);
        @(negedge clk);
        check("arst pre addr", req_if.req_addr, 32'h1004);
        #2 rstnn = 1'b0;
        #1;
        check_idle("arst");
        check("arst addr",   req_if.req_addr,         32'd0);
        check("arst last",   32'(req_if.req_last),    32'd0);
        check("arst last_x", 32'(req_if.req_last_x),  32'd0);
        @(negedge clk);
        rstnn = 1'b1;
        @(negedge clk);
        check_idle("arst rel");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
